count_sequencer: RTL and testbench
==================================

COUNT_SEQUENCER -- requirements
Module: count_sequencer

Interface
REQ-001 Parameter: PRESCALE, default 50000000, Clock cycles per count step; legal range 2..2^26-1.
REQ-002 Port: Clock  in  1  single clock; all logic on rising edge.
REQ-003 Port: Reset  in  1  synchronous, active-high reset.
REQ-004 Port: start  in  1  raw asynchronous level; rising edge = start/resume request.
REQ-005 Port: pause  in  1  raw asynchronous level; rising edge = pause request.
REQ-006 Port: clear  in  1  raw asynchronous level; rising edge = clear request.
REQ-007 Port: terminal  in  8  count value at which the run ends; sampled live every cycle.
REQ-008 Port: count  in  8  current value fed back from the external 8-bit T-flip-flop counter.
REQ-009 Port: cnt_en  out  1  counter T-enable; one-cycle pulse per count step.
REQ-010 Port: cnt_clr_b  out  1  active-low counter clear.
REQ-011 Port: state  out  2  FSM state: IDLE=00, RUN=01, PAUSE=10, DONE=11.
REQ-012 Port: done  out  1  high while in DONE.
REQ-013 All outputs SHALL be registered.

Function
REQ-014 Each of start/pause/clear SHALL pass a 2-flop synchronizer plus a rising-edge detector, producing a one-cycle internal event.
REQ-015 An input first sampled high at edge k (low at k-1) SHALL take effect on state at edge k+2; a held-high input SHALL produce exactly one event.
REQ-016 IDLE: start event -> RUN with prescaler = 0; pause event ignored.
REQ-017 RUN: 26-bit prescaler increments each cycle; on the cycle it equals PRESCALE-1 it SHALL wrap to 0 and cnt_en SHALL pulse high for exactly one cycle.
REQ-018 RUN: if count == terminal, SHALL go to DONE at the next edge, cnt_en suppressed from that cycle on; terminal = 0 with count = 0 ends the run with no pulses.
REQ-019 RUN: pause event -> PAUSE; prescaler holds its value; no cnt_en in PAUSE.
REQ-020 PAUSE: start event -> RUN; prescaler resumes from the held value; a further pause event is ignored.
REQ-021 DONE: done = 1, cnt_en = 0; start and pause events ignored; only clear leaves DONE.
REQ-022 Clear event in any state -> IDLE, prescaler = 0, cnt_clr_b low for exactly one cycle (the cycle after the transition edge).
REQ-023 Priority for simultaneous events: clear > pause > start.
REQ-024 If terminal is changed below count during RUN, the counter SHALL continue, wrapping 255 -> 0, until count == terminal.
REQ-025 count SHALL be compared at least one cycle after each cnt_en pulse (guaranteed by PRESCALE >= 2); no double step is permitted.

Reset
REQ-026 While Reset is high: state = IDLE, prescaler = 0, synchronizer and edge flops = 0, cnt_en = 0, done = 0, cnt_clr_b = 0.
REQ-027 cnt_clr_b SHALL return high on the first edge after Reset deasserts.
REQ-028 Reset mid-RUN SHALL abort with no further cnt_en pulse.
REQ-029 Input levels already high at Reset release SHALL NOT generate events.

Structure
REQ-030 A shared package SHALL hold the state encodings (IDLE/RUN/PAUSE/DONE), the prescaler width (26) and the PRESCALE default.
REQ-031 One sub-module, edge_sync (2-flop synchronizer plus rising-edge pulse, reset to 0), SHALL be instantiated three times.
REQ-032 The FSM, prescaler and output registers SHALL reside in count_sequencer; no counter datapath is duplicated inside.

Verification
Benches use PRESCALE = 4 with a behavioural 8-bit counter model on cnt_en/cnt_clr_b.
REQ-033 Reset, terminal=5, start pulse -> RUN; cnt_en every 4 cycles, exactly 5 pulses; count=5; state=11; done=1.
REQ-034 terminal=10, pause after 3 pulses, hold 20 cycles, then start -> no cnt_en during PAUSE; first resumed pulse arrives after the remaining prescaler cycles; 10 total pulses, then DONE.
REQ-035 Raise start and clear on the same cycle during RUN -> state=IDLE; one cycle of cnt_clr_b=0; count=0; no further cnt_en.
REQ-036 terminal=0, count=0, start -> DONE with zero cnt_en pulses.
REQ-037 count=200, terminal set to 3 during RUN -> 59 pulses (200 -> 255 -> 0 -> 3), then DONE.
REQ-038 Reset asserted mid-RUN with start held high through release -> state=IDLE, cnt_clr_b=0 during Reset, no event after release.

Source files
------------

// File: rtl/count_sequencer_pkg.sv
// Shared encodings and sizes for the count sequencer.
// Imported by the sequencer top and its bench.
package count_sequencer_pkg;

  localparam int PRESC_W      = 26;
  localparam int PRESCALE_DEF = 50000000;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_PAUSE = 2'b10;
  localparam logic [1:0] ST_DONE  = 2'b11;

  typedef struct packed {
    logic clr;
    logic pause;
    logic start;
  } seq_evt_t;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer with a one-cycle rising-edge pulse.
// A level already high when reset releases never pulses.
module edge_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_rise
);

  logic r_s1;
  logic r_s2;
  logic r_s3;
  logic r_v1;
  logic r_v2;
  logic r_arm;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1  <= 1'b0;
      r_s2  <= 1'b0;
      r_s3  <= 1'b0;
      r_v1  <= 1'b0;
      r_v2  <= 1'b0;
      r_arm <= 1'b0;
    end else begin
      r_s1  <= i_d;
      r_s2  <= r_s1;
      r_s3  <= r_s2;
      r_v1  <= 1'b1;
      r_v2  <= r_v1;
      // arm only once a genuine post-reset sample has been seen low
      r_arm <= r_arm | (r_v2 & ~r_s2);
    end
  end

  assign o_rise = r_s2 & ~r_s3 & r_arm;

endmodule

// File: rtl/count_sequencer.sv
// Run/pause/clear sequencer driving an external 8-bit T-FF counter.
// Steps the counter once every PRESCALE cycles until count hits terminal.
module count_sequencer
  import count_sequencer_pkg::*;
#(
  parameter int PRESCALE = PRESCALE_DEF
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  input  logic [7:0] terminal,
  input  logic [7:0] count,
  output logic       cnt_en,
  output logic       cnt_clr_b,
  output logic [1:0] state,
  output logic       done
);

  localparam logic [PRESC_W-1:0] P_LAST =
    PRESC_W'(PRESCALE - 1);

  seq_evt_t w_ev;

  logic [1:0]         r_state;
  logic [PRESC_W-1:0] r_presc;
  logic               r_cnt_en;
  logic               r_clr_b;
  logic               r_done;

  logic [1:0]         w_nstate;
  logic [PRESC_W-1:0] w_npresc;
  logic               w_nen;
  logic               w_nclr_b;

  edge_sync u_sync_start (
    .i_clk  (Clock),
    .i_rst  (Reset),
    .i_d    (start),
    .o_rise (w_ev.start)
  );

  edge_sync u_sync_pause (
    .i_clk  (Clock),
    .i_rst  (Reset),
    .i_d    (pause),
    .o_rise (w_ev.pause)
  );

  edge_sync u_sync_clear (
    .i_clk  (Clock),
    .i_rst  (Reset),
    .i_d    (clear),
    .o_rise (w_ev.clr)
  );

  always_comb begin
    w_nstate = r_state;
    w_npresc = r_presc;
    w_nen    = 1'b0;
    w_nclr_b = 1'b1;
    if (w_ev.clr) begin
      w_nstate = ST_IDLE;
      w_npresc = '0;
      w_nclr_b = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_ev.start) begin
            w_nstate = ST_RUN;
            w_npresc = '0;
          end
        end
        ST_RUN: begin
          // count is stale while a step is in flight
          if (w_ev.pause) begin
            w_nstate = ST_PAUSE;
          end else if (!r_cnt_en && count == terminal) begin
            w_nstate = ST_DONE;
          end else if (r_presc == P_LAST) begin
            w_npresc = '0;
            w_nen    = 1'b1;
          end else begin
            w_npresc = r_presc + PRESC_W'(1);
          end
        end
        ST_PAUSE: begin
          if (w_ev.start) begin
            w_nstate = ST_RUN;
          end
        end
        default: begin
          w_nstate = r_state;
        end
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state  <= ST_IDLE;
      r_presc  <= '0;
      r_cnt_en <= 1'b0;
      r_clr_b  <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_nstate;
      r_presc  <= w_npresc;
      r_cnt_en <= w_nen;
      r_clr_b  <= w_nclr_b;
      r_done   <= (w_nstate == ST_DONE);
    end
  end

  assign cnt_en    = r_cnt_en;
  assign cnt_clr_b = r_clr_b;
  assign state     = r_state;
  assign done      = r_done;

endmodule

// File: tb/tb_count_sequencer.sv
// Directed bench for count_sequencer with PRESCALE = 4.
// An 8-bit counter model follows cnt_en / cnt_clr_b.
module tb_count_sequencer;
  import count_sequencer_pkg::*;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       start;
  logic       pause;
  logic       clear;
  logic [7:0] terminal;
  logic [7:0] count;
  logic       cnt_en;
  logic       cnt_clr_b;
  logic [1:0] state;
  logic       done;

  logic       ld;
  logic [7:0] ld_val;

  int n_chk;
  int n_fail;
  int cyc;
  int npulse;
  int nbad;
  int nclr;
  int last_p;
  int s0;

  always #5 Clock = ~Clock;

  count_sequencer #(.PRESCALE(4)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .start     (start),
    .pause     (pause),
    .clear     (clear),
    .terminal  (terminal),
    .count     (count),
    .cnt_en    (cnt_en),
    .cnt_clr_b (cnt_clr_b),
    .state     (state),
    .done      (done)
  );

  always @(posedge Clock) begin
    if (!cnt_clr_b) count <= 8'd0;
    else if (ld) count <= ld_val;
    else if (cnt_en) count <= count + 8'd1;
  end

  task automatic chk(input string tag, input int got,
                     input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge Clock);
    cyc++;
    if (cnt_en) begin
      if (npulse > 0 && (cyc - last_p) != 4) nbad++;
      npulse++;
      last_p = cyc;
    end
    if (!cnt_clr_b && !Reset) nclr++;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic mon_clr();
    npulse = 0;
    nbad   = 0;
    nclr   = 0;
  endtask

  task automatic wait_state(input string tag,
                            input logic [1:0] s,
                            input int budget);
    int i;
    i = 0;
    while (state != s && i < budget) begin
      step();
      i++;
    end
    chk(tag, int'(state), int'(s));
  endtask

  task automatic wait_pulses(input string tag, input int n,
                             input int budget);
    int i;
    i = 0;
    while (npulse < n && i < budget) begin
      step();
      i++;
    end
    chk(tag, npulse, n);
  endtask

  task automatic go();
    start = 1'b1;
    s0 = cyc;
    steps(3);
    start = 1'b0;
  endtask

  task automatic do_clear();
    mon_clr();
    clear = 1'b1;
    steps(4);
    clear = 1'b0;
    steps(3);
  endtask

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0; last_p = 0; s0 = 0;
    mon_clr();
    Reset = 1'b1; start = 1'b0; pause = 1'b0;
    clear = 1'b0; terminal = 8'd0;
    ld = 1'b0; ld_val = 8'd0;

    steps(3);
    chk("rst_state", int'(state), int'(ST_IDLE));
    chk("rst_cnt_en", int'(cnt_en), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_clr_b", int'(cnt_clr_b), 0);
    Reset = 1'b0;
    step();
    chk("rel_clr_b", int'(cnt_clr_b), 1);
    chk("rel_count", int'(count), 0);
    steps(5);

    pause = 1'b1;
    steps(4);
    pause = 1'b0;
    steps(3);
    chk("idle_pause", int'(state), int'(ST_IDLE));

    // terminal 5
    terminal = 8'd5;
    mon_clr();
    go();
    wait_pulses("t5_first", 1, 20);
    chk("t5_latency", last_p - s0, 7);
    wait_state("t5_done", ST_DONE, 60);
    chk("t5_pulses", npulse, 5);
    chk("t5_interval", nbad, 0);
    chk("t5_count", int'(count), 5);
    chk("t5_done_o", int'(done), 1);
    go();
    pause = 1'b1;
    steps(5);
    pause = 1'b0;
    chk("done_hold", int'(state), int'(ST_DONE));
    chk("done_nopulse", npulse, 5);

    // pause / resume
    do_clear();
    chk("clr_pulse", nclr, 1);
    chk("clr_count", int'(count), 0);
    chk("clr_state", int'(state), int'(ST_IDLE));
    terminal = 8'd10;
    mon_clr();
    go();
    wait_pulses("p_three", 3, 40);
    pause = 1'b1;
    steps(4);
    chk("p_state", int'(state), int'(ST_PAUSE));
    steps(16);
    pause = 1'b0;
    steps(3);
    pause = 1'b1;
    steps(4);
    pause = 1'b0;
    chk("p_repause", int'(state), int'(ST_PAUSE));
    chk("p_nopulse", npulse, 3);
    start = 1'b1;
    s0 = cyc;
    wait_pulses("p_resume", 4, 20);
    chk("p_resume_lat", last_p - s0, 5);
    start = 1'b0;
    wait_state("p_done", ST_DONE, 60);
    chk("p_pulses", npulse, 10);
    chk("p_count", int'(count), 10);

    // start and clear together mid-run
    do_clear();
    terminal = 8'd50;
    mon_clr();
    go();
    wait_pulses("sc_run", 2, 30);
    mon_clr();
    start = 1'b1;
    clear = 1'b1;
    steps(4);
    start = 1'b0;
    clear = 1'b0;
    steps(20);
    chk("sc_state", int'(state), int'(ST_IDLE));
    chk("sc_clr_once", nclr, 1);
    chk("sc_count", int'(count), 0);
    chk("sc_nopulse", npulse, 0);

    // terminal 0 from count 0
    terminal = 8'd0;
    mon_clr();
    go();
    wait_state("z_done", ST_DONE, 20);
    chk("z_pulses", npulse, 0);
    chk("z_count", int'(count), 0);

    // wrap 200 -> 255 -> 0 -> 3
    do_clear();
    ld_val = 8'd200;
    ld = 1'b1;
    step();
    ld = 1'b0;
    step();
    chk("w_load", int'(count), 200);
    terminal = 8'd255;
    mon_clr();
    go();
    steps(2);
    terminal = 8'd3;
    wait_state("w_done", ST_DONE, 400);
    chk("w_pulses", npulse, 59);
    chk("w_count", int'(count), 3);

    // reset mid-run, start held through release
    do_clear();
    terminal = 8'd100;
    mon_clr();
    go();
    wait_pulses("r_run", 2, 30);
    start = 1'b1;
    steps(2);
    Reset = 1'b1;
    mon_clr();
    steps(3);
    chk("r_state", int'(state), int'(ST_IDLE));
    chk("r_clr_b", int'(cnt_clr_b), 0);
    chk("r_count", int'(count), 0);
    steps(2);
    Reset = 1'b0;
    steps(25);
    chk("r_idle", int'(state), int'(ST_IDLE));
    chk("r_nopulse", npulse, 0);
    chk("r_clr_hi", int'(cnt_clr_b), 1);
    start = 1'b0;
    steps(2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
